// File: rtl/offset_checker.sv
// Consumer-side checker: regenerates the num/range/step offset sequence,
// compares it against a valid/ready stream and records mismatch statistics.
module offset_checker (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start,
  input  logic [7:0]  io_num,
  input  logic [31:0] io_range,
  input  logic [31:0] io_step,
  input  logic [31:0] io_total,
  input  logic        io_in_valid,
  input  logic [31:0] io_in_offset,
  output logic        io_in_ready,
  output logic        io_busy,
  output logic        io_done,
  output logic [31:0] io_checked,
  output logic [31:0] io_err_count,
  output logic        io_first_err_valid,
  output logic [31:0] io_first_err_index,
  output logic [31:0] io_first_err_expected,
  output logic [31:0] io_first_err_actual
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_num, r_round, w_round_nxt;
  logic [31:0] r_range, r_step, r_total, r_exp, w_exp_nxt;
  logic [32:0] w_sum;
  logic        w_start, w_hs, w_last, w_mis;

  assign w_start = io_start && (r_state != RUN);
  assign w_hs    = io_in_valid && (r_state == RUN);
  assign w_last  = w_hs && ((io_checked + 32'd1) == r_total);
  assign w_mis   = io_in_offset != r_exp;
  assign w_sum   = {1'b0, r_exp} + {1'b0, r_step};

  assign io_in_ready = (r_state == RUN);
  assign io_busy     = (r_state == RUN);
  assign io_done     = (r_state == DONE);

  // Sequence advances from the expected value, so a corrupt offset never resyncs it.
  always_comb begin
    w_exp_nxt   = r_exp;
    w_round_nxt = r_round;
    if ((r_num != 8'd0) && (r_round == r_num - 8'd1)) begin
      w_exp_nxt   = 32'd0;
      w_round_nxt = 8'd0;
    end else begin
      w_exp_nxt   = (w_sum >= {1'b0, r_range}) ? 32'd0 : w_sum[31:0];
      w_round_nxt = r_round + 8'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (io_start) w_next = (io_total == 32'd0) ? DONE : RUN;
      RUN:        if (w_last)   w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_num                 <= '0;
      r_range               <= '0;
      r_step                <= '0;
      r_total               <= '0;
      r_exp                 <= '0;
      r_round               <= '0;
      io_checked            <= '0;
      io_err_count          <= '0;
      io_first_err_valid    <= 1'b0;
      io_first_err_index    <= '0;
      io_first_err_expected <= '0;
      io_first_err_actual   <= '0;
    end else if (w_start) begin
      r_num                 <= io_num;
      r_range               <= io_range;
      r_step                <= io_step;
      r_total               <= io_total;
      r_exp                 <= '0;
      r_round               <= '0;
      io_checked            <= '0;
      io_err_count          <= '0;
      io_first_err_valid    <= 1'b0;
      io_first_err_index    <= '0;
      io_first_err_expected <= '0;
      io_first_err_actual   <= '0;
    end else if (w_hs) begin
      r_exp      <= w_exp_nxt;
      r_round    <= w_round_nxt;
      io_checked <= io_checked + 32'd1;
      if (w_mis) begin
        if (io_err_count != 32'hFFFF_FFFF) io_err_count <= io_err_count + 32'd1;
        if (!io_first_err_valid) begin
          io_first_err_valid    <= 1'b1;
          io_first_err_index    <= io_checked;
          io_first_err_expected <= r_exp;
          io_first_err_actual   <= io_in_offset;
        end
      end
    end
  end
endmodule

// File: tb/tb_offset_checker.sv
// Directed bench for offset_checker: drives on the falling edge, checks on the falling edge.
module tb_offset_checker;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_start = 1'b0;
  logic [7:0]  io_num = '0;
  logic [31:0] io_range = '0, io_step = '0, io_total = '0;
  logic        io_in_valid = 1'b0;
  logic [31:0] io_in_offset = '0;
  logic        io_in_ready, io_busy, io_done, io_first_err_valid;
  logic [31:0] io_checked, io_err_count, io_first_err_index;
  logic [31:0] io_first_err_expected, io_first_err_actual;

  int checks = 0;
  int errors = 0;

  offset_checker dut (
    .clock(clock), .reset(reset), .io_start(io_start), .io_num(io_num),
    .io_range(io_range), .io_step(io_step), .io_total(io_total),
    .io_in_valid(io_in_valid), .io_in_offset(io_in_offset),
    .io_in_ready(io_in_ready), .io_busy(io_busy), .io_done(io_done),
    .io_checked(io_checked), .io_err_count(io_err_count),
    .io_first_err_valid(io_first_err_valid), .io_first_err_index(io_first_err_index),
    .io_first_err_expected(io_first_err_expected), .io_first_err_actual(io_first_err_actual)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] n, input logic [31:0] r, input logic [31:0] s,
                       input logic [31:0] t);
    io_num = n; io_range = r; io_step = s; io_total = t; io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
  endtask

  // One offset; optional idle cycle with valid low before presenting it.
  task automatic send(input logic [31:0] off, input bit gap);
    int n;
    if (gap) begin io_in_valid = 1'b0; @(negedge clock); end
    io_in_valid = 1'b1; io_in_offset = off;
    n = 0;
    while (!io_in_ready && n < 20) begin @(negedge clock); n++; end
    if (n == 20) begin
      checks++; errors++;
      $error("FAIL send_timeout observed=%h expected=ready", off);
    end
    @(negedge clock);
    io_in_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [31:0] nchk, input logic [31:0] nerr,
                            input logic fv, input logic [31:0] fi, input logic [31:0] fe,
                            input logic [31:0] fa);
    chk({tag, "_done"},    {31'd0, io_done}, 32'd1);
    chk({tag, "_ready"},   {31'd0, io_in_ready}, 32'd0);
    chk({tag, "_busy"},    {31'd0, io_busy}, 32'd0);
    chk({tag, "_checked"}, io_checked, nchk);
    chk({tag, "_errcnt"},  io_err_count, nerr);
    chk({tag, "_fvalid"},  {31'd0, io_first_err_valid}, {31'd0, fv});
    chk({tag, "_findex"},  io_first_err_index, fi);
    chk({tag, "_fexp"},    io_first_err_expected, fe);
    chk({tag, "_fact"},    io_first_err_actual, fa);
  endtask

  initial begin
    logic [31:0] wrap [6];
    wrap = '{32'h0, 32'h20, 32'h40, 32'h0, 32'h20, 32'h40};

    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, io_in_ready}, 32'd0);
    chk("rst_busy",  {31'd0, io_busy}, 32'd0);
    chk("rst_done",  {31'd0, io_done}, 32'd0);
    chk("rst_checked", io_checked, 32'd0);
    chk("rst_fvalid", {31'd0, io_first_err_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Ideal stream, full rate
    start(8'd8, 32'h1000, 32'd32, 32'd16);
    chk("seq_busy",  {31'd0, io_busy}, 32'd1);
    chk("seq_ready", {31'd0, io_in_ready}, 32'd1);
    for (int k = 0; k < 16; k++) send((k % 8) * 32, 1'b0);
    chk_result("seq", 32'd16, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);

    // Single corruption at index 4
    start(8'd8, 32'h1000, 32'd32, 32'd16);
    for (int k = 0; k < 16; k++) send((k == 4) ? 32'h81 : (k % 8) * 32, 1'b0);
    chk_result("cor", 32'd16, 32'd1, 1'b1, 32'd4, 32'h80, 32'h81);

    // Range wrap
    start(8'd0, 32'h60, 32'h20, 32'd6);
    for (int k = 0; k < 6; k++) send(wrap[k], 1'b0);
    chk_result("wrap", 32'd6, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);

    // step >= range: all zeros
    start(8'd0, 32'h60, 32'h70, 32'd6);
    for (int k = 0; k < 6; k++) send(32'h0, 1'b0);
    chk_result("bigstep", 32'd6, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);

    // Valid gaps with checked tracking handshakes only
    start(8'd8, 32'h1000, 32'd32, 32'd16);
    for (int k = 0; k < 16; k++) begin
      send((k % 8) * 32, bit'($urandom_range(0, 1)));
      if (k == 7) chk("gap_mid_checked", io_checked, 32'd8);
    end
    chk_result("gap", 32'd16, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);

    // total = 0
    start(8'd4, 32'h100, 32'd4, 32'd0);
    chk("t0_done",  {31'd0, io_done}, 32'd1);
    chk("t0_ready", {31'd0, io_in_ready}, 32'd0);
    chk("t0_checked", io_checked, 32'd0);

    // Start during RUN is ignored
    start(8'd0, 32'h100, 32'd4, 32'd4);
    send(32'd0, 1'b0);
    send(32'd4, 1'b0);
    start(8'd1, 32'h10, 32'd1, 32'd0);
    chk("ign_busy", {31'd0, io_busy}, 32'd1);
    chk("ign_checked", io_checked, 32'd2);
    send(32'd8, 1'b0);
    send(32'd12, 1'b0);
    chk_result("ign", 32'd4, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);

    // Reset mid-run after 3 handshakes, 1 error
    start(8'd0, 32'h100, 32'h20, 32'd8);
    send(32'h0, 1'b0);
    send(32'h21, 1'b0);
    send(32'h40, 1'b0);
    chk("mr_checked", io_checked, 32'd3);
    chk("mr_errcnt", io_err_count, 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_rst_checked", io_checked, 32'd0);
    chk("mr_rst_errcnt", io_err_count, 32'd0);
    chk("mr_rst_fvalid", {31'd0, io_first_err_valid}, 32'd0);
    chk("mr_rst_fact", io_first_err_actual, 32'd0);
    chk("mr_rst_busy", {31'd0, io_busy}, 32'd0);
    chk("mr_rst_ready", {31'd0, io_in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mr_idle_done", {31'd0, io_done}, 32'd0);
    start(8'd0, 32'h100, 32'h20, 32'd4);
    for (int k = 0; k < 4; k++) send(k * 32'h20, 1'b0);
    chk_result("fresh", 32'd4, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
